// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   REG_W    : architectural register specifier width
//   STATE_W  : width of the hazard FSM state encoding
//   CNT_W    : width of the load-use stall down-counter (covers 1..7 cycles)
//   hz_state_e : FSM states; encoding 3 is never entered and is treated as RUN
package hazard_pkg;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned STATE_W = 2;
  localparam int unsigned CNT_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hz_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
// Flags a hazard when the load in EX writes a non-zero register that the
// instruction in ID reads (rs always, rt only when ID_uses_rt is set).
// Ports:
//   ID_rs, ID_rt    : source registers of the instruction in ID
//   ID_uses_rt      : ID instruction reads rt as a source
//   ID_EX_mem_read  : instruction in EX is a load
//   ID_EX_rt        : destination register of the load in EX
//   hazard          : load-use hazard present
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_uses_rt,
  input  logic             ID_EX_mem_read,
  input  logic [REG_W-1:0] ID_EX_rt,
  output logic             hazard
);

  always_comb begin
    hazard = ID_EX_mem_read && (ID_EX_rt != '0) &&
             ((ID_EX_rt == ID_rs) || (ID_uses_rt && (ID_EX_rt == ID_rt)));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// MEM-stage wait holds for a classic 5-stage pipeline.
// Priority in every state: memory wait > branch flush > load-use stall.
// Optional statistics counters are built when HAZARD_STATS_EN is defined;
// otherwise the counter outputs are tied to zero and clear_stats_i is ignored.
// Parameters:
//   LU_STALL_CYC : load-use stall length in cycles (1..7)
//   STAT_W       : statistics counter width
// Ports:
//   clk_i, rst_i            : clock, asynchronous active-low reset
//   ID_rs, ID_rt, ID_uses_rt: ID-stage source operands
//   ID_EX_mem_read, ID_EX_rt: load currently in EX
//   EX_branch_taken         : branch resolved taken in EX
//   dmem_req, dmem_ready    : MEM-stage access handshake
//   pc_write .. ID_EX_flush : pipeline register enables / flushes
//   state_o                 : current FSM state encoding
//   clear_stats_i           : zero the statistics counters
//   stall_cnt_o, flush_cnt_o: cycles with pc_write low / branch-flush cycles
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned LU_STALL_CYC = 1,
  parameter int unsigned STAT_W       = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [REG_W-1:0]   ID_rs,
  input  logic [REG_W-1:0]   ID_rt,
  input  logic               ID_uses_rt,
  input  logic               ID_EX_mem_read,
  input  logic [REG_W-1:0]   ID_EX_rt,
  input  logic               EX_branch_taken,
  input  logic               dmem_req,
  input  logic               dmem_ready,
  output logic               pc_write,
  output logic               IF_ID_write,
  output logic               ID_EX_write,
  output logic               EX_MEM_hold,
  output logic               IF_ID_flush,
  output logic               ID_EX_flush,
  output logic [STATE_W-1:0] state_o,
  input  logic               clear_stats_i,
  output logic [STAT_W-1:0]  stall_cnt_o,
  output logic [STAT_W-1:0]  flush_cnt_o
);

  localparam logic [CNT_W-1:0] LU_RELOAD = CNT_W'(LU_STALL_CYC - 1);

  hz_state_e        state_q, state_d;
  hz_state_e        ret_q, ret_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu_hazard;
  logic             in_lu, in_wait, mem_wait;

  load_use_detect u_detect (
    .ID_rs          (ID_rs),
    .ID_rt          (ID_rt),
    .ID_uses_rt     (ID_uses_rt),
    .ID_EX_mem_read (ID_EX_mem_read),
    .ID_EX_rt       (ID_EX_rt),
    .hazard         (lu_hazard)
  );

  // Any encoding other than LU_STALL / MEM_WAIT behaves as RUN.
  always_comb begin
    in_lu    = (state_q == ST_LU_STALL);
    in_wait  = (state_q == ST_MEM_WAIT);
    mem_wait = !dmem_ready && (dmem_req || in_wait);
  end

  always_comb begin
    pc_write    = 1'b1;
    IF_ID_write = 1'b1;
    ID_EX_write = 1'b1;
    EX_MEM_hold = 1'b0;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    state_d     = ST_RUN;
    ret_d       = ret_q;
    cnt_d       = cnt_q;

    if (mem_wait) begin
      // Whole pipe frozen; the stall counter is left untouched so a
      // load-use stall resumes where it stopped.
      pc_write    = 1'b0;
      IF_ID_write = 1'b0;
      ID_EX_write = 1'b0;
      EX_MEM_hold = 1'b1;
      state_d     = ST_MEM_WAIT;
      if (!in_wait) ret_d = in_lu ? ST_LU_STALL : ST_RUN;
    end else if (EX_branch_taken) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
      cnt_d       = '0;
      ret_d       = ST_RUN;
    end else if (in_wait) begin
      // Access completed: holds drop this cycle, resume the interrupted state.
      state_d = ret_q;
      ret_d   = ST_RUN;
    end else if (in_lu || lu_hazard) begin
      pc_write    = 1'b0;
      IF_ID_write = 1'b0;
      ID_EX_flush = 1'b1;
      if (in_lu) begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d = '0;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = ST_LU_STALL;
        end
      end else if (LU_STALL_CYC > 1) begin
        cnt_d   = LU_RELOAD;
        state_d = ST_LU_STALL;
      end
    end

    // Reset overrides the combinational outputs so the pipe sees defaults.
    if (!rst_i) begin
      pc_write    = 1'b1;
      IF_ID_write = 1'b1;
      ID_EX_write = 1'b1;
      EX_MEM_hold = 1'b0;
      IF_ID_flush = 1'b0;
      ID_EX_flush = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_RUN;
      ret_q   <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (clear_stats_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_write && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + STAT_W'(1);
      if (IF_ID_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + STAT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  logic unused_clear_stats;
  assign unused_clear_stats = clear_stats_i;
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Two instances share stimulus:
// dut_a uses a 1-cycle load-use stall with 4-bit statistics, dut_b a 3-cycle
// stall with 16-bit statistics. Expected values are packed as
// {pc_write, IF_ID_write, ID_EX_write, EX_MEM_hold, IF_ID_flush, ID_EX_flush, state[1:0]}.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       uses_rt, mem_read, br, dreq, drdy, clr;

  logic        a_pc, a_ifw, a_idw, a_hold, a_iff, a_idf;
  logic [1:0]  a_st;
  logic [3:0]  a_stall, a_flush;
  logic        b_pc, b_ifw, b_idw, b_hold, b_iff, b_idf;
  logic [1:0]  b_st;
  logic [15:0] b_stall, b_flush;
  logic [7:0]  obs_a, obs_b;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  assign obs_a = {a_pc, a_ifw, a_idw, a_hold, a_iff, a_idf, a_st};
  assign obs_b = {b_pc, b_ifw, b_idw, b_hold, b_iff, b_idf, b_st};

  pipeline_hazard_ctrl #(.LU_STALL_CYC(1), .STAT_W(4)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .ID_rs(id_rs), .ID_rt(id_rt), .ID_uses_rt(uses_rt),
    .ID_EX_mem_read(mem_read), .ID_EX_rt(ex_rt), .EX_branch_taken(br),
    .dmem_req(dreq), .dmem_ready(drdy),
    .pc_write(a_pc), .IF_ID_write(a_ifw), .ID_EX_write(a_idw), .EX_MEM_hold(a_hold),
    .IF_ID_flush(a_iff), .ID_EX_flush(a_idf), .state_o(a_st),
    .clear_stats_i(clr), .stall_cnt_o(a_stall), .flush_cnt_o(a_flush)
  );

  pipeline_hazard_ctrl #(.LU_STALL_CYC(3), .STAT_W(16)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .ID_rs(id_rs), .ID_rt(id_rt), .ID_uses_rt(uses_rt),
    .ID_EX_mem_read(mem_read), .ID_EX_rt(ex_rt), .EX_branch_taken(br),
    .dmem_req(dreq), .dmem_ready(drdy),
    .pc_write(b_pc), .IF_ID_write(b_ifw), .ID_EX_write(b_idw), .EX_MEM_hold(b_hold),
    .IF_ID_flush(b_iff), .ID_EX_flush(b_idf), .state_o(b_st),
    .clear_stats_i(clr), .stall_cnt_o(b_stall), .flush_cnt_o(b_flush)
  );

  task automatic set_idle();
    id_rs = '0; id_rt = '0; ex_rt = '0; uses_rt = 1'b0; mem_read = 1'b0;
    br = 1'b0; dreq = 1'b0; drdy = 1'b1; clr = 1'b0;
  endtask

  // code = {load-use hazard on rs=8, branch taken, dmem_req, dmem not ready}
  task automatic apply(input logic [3:0] code);
    set_idle();
    if (code[3]) begin mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; end
    br   = code[2];
    dreq = code[1];
    drdy = !code[0];
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    dreq = 1'b1; drdy = 1'b0;  // would be a mem-wait outside reset
    rst_n = 1'b0;
    #3;
    compared++; if (obs_a !== 8'hE0) begin mismatched++; $display("FAIL reset_a: got %h want %h", obs_a, 8'hE0); end
    compared++; if (obs_b !== 8'hE0) begin mismatched++; $display("FAIL reset_b: got %h want %h", obs_b, 8'hE0); end
    compared++; if (a_stall !== 4'd0 || a_flush !== 4'd0) begin mismatched++;
      $display("FAIL reset_stats: got %0d/%0d want 0/0", a_stall, a_flush); end
    @(posedge clk);
    #1;
    set_idle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_load_use();
    logic [3:0] st [4] = '{4'h8, 4'h0, 4'h0, 4'h0};
    logic [7:0] ea [4] = '{8'h24, 8'hE0, 8'hE0, 8'hE0};
    logic [7:0] eb [4] = '{8'h24, 8'h25, 8'h25, 8'hE0};
    for (int i = 0; i < 4; i++) begin
      apply(st[i]); #1;
      compared++; if (obs_a !== ea[i]) begin mismatched++; $display("FAIL load_use_a[%0d]: got %h want %h", i, obs_a, ea[i]); end
      compared++; if (obs_b !== eb[i]) begin mismatched++; $display("FAIL load_use_b[%0d]: got %h want %h", i, obs_b, eb[i]); end
      next_cycle();
    end
  endtask

  task automatic test_no_hazard();
    // {mem_read, ex_rt, rs, rt, uses_rt}
    logic [16:0] v  [6] = '{{1'b1, 5'd0, 5'd0, 5'd0, 1'b0}, {1'b1, 5'd0, 5'd0, 5'd0, 1'b1},
                            {1'b1, 5'd8, 5'd3, 5'd8, 1'b0}, {1'b1, 5'd8, 5'd3, 5'd8, 1'b1},
                            {1'b0, 5'd8, 5'd8, 5'd8, 1'b1}, {1'b1, 5'd31, 5'd31, 5'd0, 1'b0}};
    logic [7:0]  ea [6] = '{8'hE0, 8'hE0, 8'hE0, 8'h24, 8'hE0, 8'h24};
    for (int i = 0; i < 6; i++) begin
      set_idle();
      {mem_read, ex_rt, id_rs, id_rt, uses_rt} = v[i];
      #1;
      compared++; if (obs_a !== ea[i]) begin mismatched++; $display("FAIL detect_a[%0d]: got %h want %h", i, obs_a, ea[i]); end
      next_cycle();
      set_idle();
      for (int k = 0; k < 3; k++) next_cycle();  // let dut_b drain any stall
    end
  endtask

  task automatic test_mem_wait_lu();
    logic [3:0] st [11] = '{4'h8, 4'h3, 4'h3, 4'h2, 4'h0, 4'h0, 4'h0, 4'h3, 4'h1, 4'h0, 4'h0};
    logic [7:0] ea [11] = '{8'h24, 8'h10, 8'h12, 8'hE2, 8'hE0, 8'hE0, 8'hE0, 8'h10, 8'h12, 8'hE2, 8'hE0};
    logic [7:0] eb [11] = '{8'h24, 8'h11, 8'h12, 8'hE2, 8'h25, 8'h25, 8'hE0, 8'h10, 8'h12, 8'hE2, 8'hE0};
    int stall_b = 0;
    int hold_b  = 0;
    for (int i = 0; i < 11; i++) begin
      apply(st[i]); #1;
      compared++; if (obs_a !== ea[i]) begin mismatched++; $display("FAIL memwait_a[%0d]: got %h want %h", i, obs_a, ea[i]); end
      compared++; if (obs_b !== eb[i]) begin mismatched++; $display("FAIL memwait_b[%0d]: got %h want %h", i, obs_b, eb[i]); end
      if (i < 7) begin
        if (!b_pc && !b_hold) stall_b++;
        if (b_hold) hold_b++;
      end
      next_cycle();
    end
    compared++; if (stall_b != 3 || hold_b != 2) begin mismatched++;
      $display("FAIL memwait_b_totals: got stall %0d hold %0d want stall 3 hold 2", stall_b, hold_b); end
  endtask

  task automatic test_branch();
    logic [3:0] st [9] = '{4'hC, 4'h0, 4'h8, 4'h4, 4'h0, 4'h0, 4'h7, 4'h6, 4'h0};
    logic [7:0] ea [9] = '{8'hEC, 8'hE0, 8'h24, 8'hEC, 8'hE0, 8'hE0, 8'h10, 8'hEE, 8'hE0};
    logic [7:0] eb [9] = '{8'hEC, 8'hE0, 8'h24, 8'hED, 8'hE0, 8'hE0, 8'h10, 8'hEE, 8'hE0};
    for (int i = 0; i < 9; i++) begin
      apply(st[i]); #1;
      compared++; if (obs_a !== ea[i]) begin mismatched++; $display("FAIL branch_a[%0d]: got %h want %h", i, obs_a, ea[i]); end
      compared++; if (obs_b !== eb[i]) begin mismatched++; $display("FAIL branch_b[%0d]: got %h want %h", i, obs_b, eb[i]); end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    apply(4'h3); next_cycle();
    apply(4'h3); #1;
    compared++; if (obs_a !== 8'h12 || obs_b !== 8'h12) begin mismatched++;
      $display("FAIL rst_mid_wait_pre: got %h/%h want 12/12", obs_a, obs_b); end
    #2 rst_n = 1'b0;
    #1;
    compared++; if (obs_a !== 8'hE0 || obs_b !== 8'hE0) begin mismatched++;
      $display("FAIL rst_mid_wait: got %h/%h want e0/e0", obs_a, obs_b); end
    next_cycle();
    set_idle(); rst_n = 1'b1; #1;
    compared++; if (obs_a !== 8'hE0 || obs_b !== 8'hE0) begin mismatched++;
      $display("FAIL rst_mid_wait_post: got %h/%h want e0/e0", obs_a, obs_b); end
    next_cycle();
    apply(4'h8); next_cycle();
    apply(4'h0); #1;
    compared++; if (obs_b !== 8'h25) begin mismatched++; $display("FAIL rst_mid_lu_pre: got %h want 25", obs_b); end
    #2 rst_n = 1'b0;
    #1;
    compared++; if (obs_b !== 8'hE0) begin mismatched++; $display("FAIL rst_mid_lu: got %h want e0", obs_b); end
    #1 rst_n = 1'b1;
    next_cycle();
    apply(4'h0); #1;
    compared++; if (obs_b !== 8'hE0) begin mismatched++; $display("FAIL rst_mid_lu_post: got %h want e0", obs_b); end
    next_cycle();
  endtask

  task automatic test_stats();
    rst_n = 1'b0; #1; rst_n = 1'b1;
    apply(4'h4); next_cycle();
    apply(4'h4); next_cycle();
    set_idle(); #1;
`ifdef HAZARD_STATS_EN
    compared++; if (a_flush !== 4'd2 || b_flush !== 16'd2) begin mismatched++;
      $display("FAIL stats_flush: got %0d/%0d want 2/2", a_flush, b_flush); end
    compared++; if (a_stall !== 4'd0) begin mismatched++; $display("FAIL stats_stall_zero: got %0d want 0", a_stall); end
`else
    compared++; if (a_flush !== 4'd0 || b_flush !== 16'd0) begin mismatched++;
      $display("FAIL stats_off_flush: got %0d/%0d want 0/0", a_flush, b_flush); end
`endif
    for (int i = 0; i < 20; i++) begin apply(4'h8); next_cycle(); end
    set_idle();
    for (int i = 0; i < 3; i++) next_cycle();
`ifdef HAZARD_STATS_EN
    compared++; if (a_stall !== 4'd15) begin mismatched++; $display("FAIL stats_sat_a: got %0d want 15", a_stall); end
    compared++; if (b_stall !== 16'd21) begin mismatched++; $display("FAIL stats_stall_b: got %0d want 21", b_stall); end
`else
    compared++; if (a_stall !== 4'd0 || b_stall !== 16'd0) begin mismatched++;
      $display("FAIL stats_off_stall: got %0d/%0d want 0/0", a_stall, b_stall); end
`endif
    apply(4'h8); clr = 1'b1; next_cycle();
    set_idle(); #1;
    compared++; if (a_stall !== 4'd0 || a_flush !== 4'd0 || b_stall !== 16'd0) begin mismatched++;
      $display("FAIL stats_clear: got %0d/%0d/%0d want 0/0/0", a_stall, a_flush, b_stall); end
    next_cycle();
    apply(4'h8); next_cycle();
    set_idle(); #1;
`ifdef HAZARD_STATS_EN
    compared++; if (a_stall !== 4'd1) begin mismatched++; $display("FAIL stats_after_clear: got %0d want 1", a_stall); end
`else
    compared++; if (a_stall !== 4'd0) begin mismatched++; $display("FAIL stats_off_after: got %0d want 0", a_stall); end
`endif
    for (int i = 0; i < 3; i++) next_cycle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_mem_wait_lu();
    test_branch();
    test_reset_mid();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
